// File: rtl/scan_sub.sv
// PS-to-SoC input mailbox: the PS fills and commits a word buffer, and the SoC reads it back by address.
// When the SoC acknowledges, the mailbox returns to FILL and raises finish_ps_o for the PS.
module scan_sub #(
    parameter  int REG_NUMBER = 16,
    localparam int IW         = $clog2(REG_NUMBER),
    localparam int AW         = IW + 2,
    localparam int CW         = IW + 1
) (
    input  logic          clk_sys_i,
    input  logic          rst_i,
    input  logic          write_ps_en_i,
    input  logic [AW-1:0] ps_addr_i,
    input  logic [31:0]   ps_data_i,
    input  logic          commit_ps_i,
    output logic          finish_ps_o,
    output logic          overrun_o,
    output logic          valid_soc_o,
    output logic [CW-1:0] count_o,
    input  logic          read_soc_en_i,
    input  logic [AW-1:0] soc_addr_i,
    output logic [31:0]   soc_data_o,
    input  logic          ack_soc_i
);

    typedef enum logic [0:0] {FILL = 1'b0, READY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          write_prev_q, commit_prev_q;
    logic [CW-1:0] count_q, count_d;
    logic          finish_q, finish_d;
    logic          overrun_q, overrun_d;
    logic [31:0]   soc_data_q;
    logic [31:0]   buf_q [REG_NUMBER];

    logic          write_edge, commit_edge, buf_we;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [CW-1:0] wr_count;
    logic          unused_addr_bits;

    assign write_edge       = write_ps_en_i & ~write_prev_q;
    assign commit_edge      = commit_ps_i & ~commit_prev_q;
    assign wr_idx           = ps_addr_i[AW-1:2];
    assign rd_idx           = soc_addr_i[AW-1:2];
    assign wr_count         = {1'b0, wr_idx} + CW'(1);
    assign unused_addr_bits = ^{ps_addr_i[1:0], soc_addr_i[1:0]};

    // The prev registers reset high so that an input already high at reset release is not seen as an edge.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q       <= FILL;
            write_prev_q  <= 1'b1;
            commit_prev_q <= 1'b1;
            count_q       <= '0;
            finish_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_prev_q  <= write_ps_en_i;
            commit_prev_q <= commit_ps_i;
            count_q       <= count_d;
            finish_q      <= finish_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        finish_d  = finish_q;
        overrun_d = overrun_q;
        buf_we    = 1'b0;
        case (state_q)
            FILL: begin
                // A write that coincides with a commit still lands in the committed batch.
                if (write_edge) begin
                    buf_we   = 1'b1;
                    finish_d = 1'b0;
                    if (wr_count > count_q) count_d = wr_count;
                end
                if (commit_edge) state_d = READY;
            end
            READY: begin
                if (write_edge) overrun_d = 1'b1;
                // The ack wins over a simultaneous overrun.
                if (ack_soc_i) begin
                    state_d   = FILL;
                    finish_d  = 1'b1;
                    count_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    for (genvar gi = 0; gi < REG_NUMBER; gi++) begin : g_word
        always_ff @(posedge clk_sys_i) begin
            if (rst_i) begin
                buf_q[gi] <= '0;
            end else if (buf_we && (wr_idx == IW'(gi))) begin
                buf_q[gi] <= ps_data_i;
            end
        end
    end

    // A read and a write to the same word on the same edge return the pre-write contents.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            soc_data_q <= '0;
        end else if (read_soc_en_i) begin
            soc_data_q <= buf_q[rd_idx];
        end
    end

    assign finish_ps_o = finish_q;
    assign overrun_o   = overrun_q;
    assign valid_soc_o = (state_q == READY);
    assign count_o     = count_q;
    assign soc_data_o  = soc_data_q;

endmodule

// File: tb/tb_scan_sub.sv
// Directed and randomized checks of scan_sub against a transaction-level mailbox model.
module tb_scan_sub;

    localparam int N  = 16;
    localparam int AW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en, commit, read_en, ack;
    logic [AW-1:0] ps_addr, soc_addr;
    logic [31:0]   ps_data;
    logic          finish_o, overrun_o, valid_o;
    logic [CW-1:0] count_o;
    logic [31:0]   soc_data_o;

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level model of the mailbox
    logic [31:0] m_mem [N];
    int          m_cnt;
    bit          m_ready, m_fin, m_ovr;

    always #5 clk = ~clk;

    scan_sub #(.REG_NUMBER(N)) dut (
        .clk_sys_i     (clk),
        .rst_i         (rst),
        .write_ps_en_i (write_en),
        .ps_addr_i     (ps_addr),
        .ps_data_i     (ps_data),
        .commit_ps_i   (commit),
        .finish_ps_o   (finish_o),
        .overrun_o     (overrun_o),
        .valid_soc_o   (valid_o),
        .count_o       (count_o),
        .read_soc_en_i (read_en),
        .soc_addr_i    (soc_addr),
        .soc_data_o    (soc_data_o),
        .ack_soc_i     (ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid"},   32'(valid_o),   32'(m_ready));
        chk({tag, ".count"},   32'(count_o),   32'(m_cnt));
        chk({tag, ".finish"},  32'(finish_o),  32'(m_fin));
        chk({tag, ".overrun"}, 32'(overrun_o), 32'(m_ovr));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_cnt = 0; m_ready = 0; m_fin = 0; m_ovr = 0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a[AW-1:2]);
        if (m_ready) begin
            m_ovr = 1;
        end else begin
            m_mem[idx] = d;
            if (idx + 1 > m_cnt) m_cnt = idx + 1;
            m_fin = 0;
        end
    endtask

    task automatic ps_write(input logic [AW-1:0] a, input logic [31:0] d);
        write_en = 1; ps_addr = a; ps_data = d;
        tick();
        model_write(a, d);
        $display("txn write  addr=%h data=%h", a, d);
        check_outs("write");
        write_en = 0;
        tick();
    endtask

    task automatic ps_commit();
        commit = 1;
        tick();
        m_ready = 1;
        $display("txn commit count=%0d", m_cnt);
        check_outs("commit");
        commit = 0;
        tick();
    endtask

    task automatic write_commit(input logic [AW-1:0] a, input logic [31:0] d);
        write_en = 1; commit = 1; ps_addr = a; ps_data = d;
        tick();
        model_write(a, d);
        m_ready = 1;
        $display("txn write+commit addr=%h data=%h", a, d);
        check_outs("wrcommit");
        write_en = 0; commit = 0;
        tick();
    endtask

    task automatic soc_read(input logic [AW-1:0] a);
        read_en = 1; soc_addr = a;
        tick();
        read_en = 0;
        $display("txn read   addr=%h data=%h", a, soc_data_o);
        chk("read.data", soc_data_o, m_mem[int'(a[AW-1:2])]);
    endtask

    task automatic soc_ack();
        ack = 1;
        tick();
        ack = 0;
        if (m_ready) begin
            m_ready = 0; m_fin = 1; m_cnt = 0; m_ovr = 0;
        end
        $display("txn ack");
        check_outs("ack");
    endtask

    initial begin
        rst = 1; write_en = 1; commit = 1; read_en = 0; ack = 0;
        ps_addr = '0; ps_data = '0; soc_addr = '0;
        model_reset();

        // Reset with write and commit held high: no edge on release
        tick(); tick();
        rst = 0;
        tick(); tick();
        check_outs("reset");
        for (int i = 0; i < N; i++) soc_read(AW'(i * 4));
        write_en = 0; commit = 0;
        tick();
        check_outs("release");

        // Basic batch
        ps_write(6'h00, 32'h1111_1111);
        ps_write(6'h08, 32'h2222_2222);
        ps_commit();
        chk("basic.count3", 32'(count_o), 32'd3);
        soc_read(6'h08);
        chk("basic.read8", soc_data_o, 32'h2222_2222);
        soc_ack();

        // Simultaneous write and commit
        write_commit(6'h0C, 32'hDEAD_BEEF);
        chk("wc.count4", 32'(count_o), 32'd4);
        soc_read(6'h0C);
        chk("wc.read", soc_data_o, 32'hDEAD_BEEF);

        // Overrun in READY, buffer untouched, cleared by ack
        ps_write(6'h00, 32'hBAD0_BAD0);
        soc_read(6'h00);
        chk("ovr.buf0", soc_data_o, 32'h1111_1111);
        soc_ack();

        // Ack in FILL is ignored; next write clears finish
        soc_ack();
        ps_write(6'h04, 32'h0404_0404);
        ps_commit();

        // Write edge on the same edge as ack: overrun set then cleared by ack
        write_en = 1; ps_addr = 6'h10; ps_data = 32'h5555_5555; ack = 1;
        tick();
        model_write(6'h10, 32'h5555_5555);
        m_ready = 0; m_fin = 1; m_cnt = 0; m_ovr = 0;
        ack = 0; write_en = 0;
        check_outs("ackwr");
        tick();
        ps_write(6'h10, 32'h6666_6666);

        // Empty commit is legal
        soc_ack();
        ps_commit();
        soc_ack();

        // Reset in READY after three writes
        ps_write(6'h00, 32'hA0A0_A0A0);
        ps_write(6'h14, 32'hA1A1_A1A1);
        ps_write(6'h3C, 32'hA2A2_A2A2);
        ps_commit();
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        check_outs("midrst");
        chk("midrst.soc", soc_data_o, 32'h0);
        for (int i = 0; i < N; i++) soc_read(AW'(i * 4));

        // Randomized mix of transactions
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            a = AW'($urandom);
            d = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ps_write(a, d);
                4:          ps_commit();
                5:          write_commit(a, d);
                6, 7:       soc_read(a);
                default:    soc_ack();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/scan_sub.md
# scan_sub

PS-to-SoC input mailbox; the reverse path to the print channel. The PS side writes up to REG_NUMBER 32-bit words into a local buffer and commits them. The SoC side then reads the words by address and acknowledges. The block reports completion back to the PS with a level `finish_ps_o`, using the same edge-triggered, finish-flag handshake style as the print path.

## Interface
Parameters:
- REG_NUMBER, 16, number of 32-bit buffer words; must be a power of two, ≥ 2.

Ports (AW = $clog2(REG_NUMBER)+2, byte address; bits [1:0] ignored; index = addr[AW-1:2]):
- clk_sys_i  in  1  system clock; single clock domain; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- write_ps_en_i  in  1  PS write request; level input, acted on at its rising edge only.
- ps_addr_i  in  AW  PS write byte address.
- ps_data_i  in  32  PS write data.
- commit_ps_i  in  1  PS commit request; acted on at its rising edge only.
- finish_ps_o  out  1  SoC has consumed the last committed batch.
- overrun_o  out  1  sticky flag: a PS write was attempted while in READY.
- valid_soc_o  out  1  a committed batch is available to the SoC (state READY).
- count_o  out  $clog2(REG_NUMBER)+1  highest written index + 1 in the current batch.
- read_soc_en_i  in  1  SoC read strobe; one read per high cycle.
- soc_addr_i  in  AW  SoC read byte address.
- soc_data_o  out  32  read data, registered.
- ack_soc_i  in  1  SoC release strobe; a single-cycle pulse.

## Operation
- Edge detection:
  - write_prev and commit_prev are registered copies of the inputs.
  - edge = input & ~prev.
  - Both prev registers reset to 1, so an input already high at reset release produces no edge.
- States: FILL (reset state) and READY.
- FILL:
  - On a write edge: buf[index] ← ps_data_i; count_o ← max(count_o, index+1); finish_ps_o ← 0.
  - On a commit edge: go to READY; valid_soc_o ← 1.
  - Write edge and commit edge in the same cycle: the write is stored and count_o is updated first, then the state becomes READY. The committed batch includes that word.
  - A commit with count_o = 0 is legal; it enters READY with count_o = 0.
- READY:
  - A write edge does not change the buffer and sets overrun_o ← 1.
  - A commit edge is ignored.
  - On ack_soc_i: go to FILL; valid_soc_o ← 0; finish_ps_o ← 1; count_o ← 0; overrun_o ← 0.
- ack_soc_i in FILL is ignored.
- Reads:
  - With read_soc_en_i high: soc_data_o ← buf[soc index] on the next edge, in any state.
  - Otherwise soc_data_o holds its value.
  - Read and write to the same index in the same cycle return the old data.
- count_o is saturation-free: index+1 ≤ REG_NUMBER always fits.
- Reset values: buf all 0, soc_data_o 0, valid_soc_o 0, finish_ps_o 0, overrun_o 0, count_o 0, state FILL.

## Timing
- Write/commit latency: input rises in cycle N (sampled at edge N). Effects (buffer, count_o, valid_soc_o, finish_ps_o) are visible after edge N.
- The input must stay high ≥ 1 cycle. Holding it high produces no further actions; it must return low for ≥ 1 cycle before the next edge.
- ps_addr_i and ps_data_i must be stable in the cycle the write edge is sampled.
- Read latency: 1 cycle; data for the strobe at edge N is valid after edge N.
- ack_soc_i at edge N: valid_soc_o = 0 and finish_ps_o = 1 after edge N.
  - A write edge at N+1 is accepted (FILL) and clears finish_ps_o after edge N+1.
  - A write edge at edge N itself is still treated as a READY write: overrun_o is set, then cleared by the same ack. Ack has priority, so overrun_o = 0 after edge N.
- Reset mid-operation: rst_i high at any edge forces all reset values after that edge, regardless of pending edges or state. The batch is lost and finish_ps_o = 0.

## Test plan
- Reset with write_ps_en_i and commit_ps_i held high → no write, no commit; all outputs 0; stays FILL until the inputs toggle low then high.
- PS writes 0x11111111 @0x0, 0x22222222 @0x8, then commits → count_o = 3, valid_soc_o = 1. SoC reads 0x8 → soc_data_o = 0x22222222 one cycle later. Ack → finish_ps_o = 1, valid_soc_o = 0, count_o = 0.
- Write edge and commit edge in the same cycle, data 0xDEADBEEF @0xC → READY with count_o = 4; read 0xC → 0xDEADBEEF.
- Write edge during READY with 0xBAD0BAD0 @0x0 → overrun_o = 1, buf[0] unchanged; ack → overrun_o = 0.
- After ack, next PS write edge → finish_ps_o falls after that edge. Ack pulsed in FILL → no state change.
- rst_i asserted in READY after 3 writes → valid_soc_o = 0, count_o = 0, every read returns 0.
